// File: rtl/i2c_bus_arbiter_pkg.sv
// Shared I2C definitions: controller transfer modes and the bus arbiter state encoding.
package i2c_pkg;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_LAUNCH  = 2'd1,
    ARB_ACTIVE  = 2'd2,
    ARB_HOLDOFF = 2'd3
  } arb_state_t;

endpackage

// File: rtl/i2c_bus_arbiter_if.sv
// Client-side request/response bundle plus the i2c_controller handshake of the bus arbiter.
interface i2c_bus_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req;
  logic [7*NREQ-1:0] req_addr;
  logic [NREQ-1:0]   req_mode;
  logic [8*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic [NREQ-1:0]   err;
  logic [7:0]        rdata;
  logic              busy;
  logic              i2c_enable;
  logic              i2c_mode;
  logic [6:0]        i2c_periph_addr;
  logic [7:0]        i2c_transmit_byte;
  logic              i2c_ready;
  logic [7:0]        i2c_read_byte;

  modport master (
    input  req, req_addr, req_mode, req_wdata, i2c_ready, i2c_read_byte,
    output grant, done, err, rdata, busy,
    output i2c_enable, i2c_mode, i2c_periph_addr, i2c_transmit_byte
  );

  modport slave (
    output req, req_addr, req_mode, req_wdata, i2c_ready, i2c_read_byte,
    input  grant, done, err, rdata, busy,
    input  i2c_enable, i2c_mode, i2c_periph_addr, i2c_transmit_byte
  );
endinterface

// File: rtl/i2c_bus_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request searching upward (mod NREQ) from pointer+1.
module rr_pick #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_ptr,
  output logic [NREQ-1:0]         o_onehot,
  output logic [$clog2(NREQ)-1:0] o_idx,
  output logic                    o_valid
);
  localparam int IW = $clog2(NREQ);

  always_comb begin
    int cand;
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    cand     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(i_ptr) + k) % NREQ;
      if (!o_valid && i_req[cand]) begin
        o_valid        = 1'b1;
        o_idx          = IW'(cand);
        o_onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one i2c_controller between NREQ clients; one down-counter
// serves as the transaction timeout while busy and as the settle delay afterwards.
module i2c_bus_arbiter
  import i2c_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 4096,
  parameter int HOLDOFF = 8
) (
  input  logic              clk,
  input  logic              reset,
  i2c_bus_arbiter_if.master bus
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + HOLDOFF) + 1;

  arb_state_t      r_state, w_state_next;
  logic [IW-1:0]   r_ptr, w_ptr_next;
  logic [CW-1:0]   r_cnt, w_cnt_next, w_cnt_dec;
  logic [NREQ-1:0] r_grant, w_grant_next;
  logic [NREQ-1:0] r_done, w_done_next;
  logic [NREQ-1:0] r_err, w_err_next;
  logic [7:0]      r_rdata, w_rdata_next;
  logic            r_enable, w_enable_next;
  logic            r_mode, w_mode_next;
  logic [6:0]      r_addr, w_addr_next;
  logic [7:0]      r_wdata, w_wdata_next;
  logic            w_finish, w_abort;

  logic [NREQ-1:0] w_win_onehot;
  logic [IW-1:0]   w_win_idx;
  logic            w_win_valid;
  logic [6:0]      w_req_addr  [NREQ];
  logic [7:0]      w_req_wdata [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign w_req_addr[gi]  = bus.req_addr[7*gi +: 7];
      assign w_req_wdata[gi] = bus.req_wdata[8*gi +: 8];
    end
  endgenerate

  rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req    (bus.req),
    .i_ptr    (r_ptr),
    .o_onehot (w_win_onehot),
    .o_idx    (w_win_idx),
    .o_valid  (w_win_valid)
  );

  // Saturating decrement so the counter can never wrap past zero.
  assign w_cnt_dec = (r_cnt == '0) ? '0 : r_cnt - CW'(1);

  always_comb begin
    w_state_next  = r_state;
    w_ptr_next    = r_ptr;
    w_cnt_next    = r_cnt;
    w_grant_next  = r_grant;
    w_done_next   = '0;
    w_err_next    = '0;
    w_rdata_next  = r_rdata;
    w_enable_next = r_enable;
    w_mode_next   = r_mode;
    w_addr_next   = r_addr;
    w_wdata_next  = r_wdata;
    w_finish      = 1'b0;
    w_abort       = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_win_valid) begin
          w_addr_next   = w_req_addr[w_win_idx];
          w_mode_next   = bus.req_mode[w_win_idx];
          w_wdata_next  = w_req_wdata[w_win_idx];
          w_grant_next  = w_win_onehot;
          w_enable_next = 1'b1;
          w_ptr_next    = w_win_idx;
          w_cnt_next    = CW'(TIMEOUT - 1);
          w_state_next  = ARB_LAUNCH;
        end
      end
      ARB_LAUNCH: begin
        if (r_cnt == CW'(1)) begin
          w_abort = 1'b1;
        end else begin
          w_cnt_next = w_cnt_dec;
          if (!bus.i2c_ready) w_state_next = ARB_ACTIVE;
        end
      end
      ARB_ACTIVE: begin
        // A completion landing on the last allowed cycle still counts as done.
        if (bus.i2c_ready)            w_finish   = 1'b1;
        else if (r_cnt == CW'(1))     w_abort    = 1'b1;
        else                          w_cnt_next = w_cnt_dec;
      end
      ARB_HOLDOFF: begin
        if (r_cnt <= CW'(1)) w_state_next = ARB_IDLE;
        else                 w_cnt_next   = w_cnt_dec;
      end
      default: w_state_next = ARB_IDLE;
    endcase

    if (w_finish || w_abort) begin
      w_enable_next = 1'b0;
      w_grant_next  = '0;
      w_cnt_next    = CW'(HOLDOFF);
      w_state_next  = ARB_HOLDOFF;
      if (w_finish) begin
        w_done_next = r_grant;
        if (r_mode == MODE_READ) w_rdata_next = bus.i2c_read_byte;
      end else begin
        w_err_next = r_grant;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ARB_IDLE;
      r_ptr    <= IW'(NREQ - 1);
      r_cnt    <= '0;
      r_grant  <= '0;
      r_done   <= '0;
      r_err    <= '0;
      r_rdata  <= '0;
      r_enable <= 1'b0;
      r_mode   <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      r_state  <= w_state_next;
      r_ptr    <= w_ptr_next;
      r_cnt    <= w_cnt_next;
      r_grant  <= w_grant_next;
      r_done   <= w_done_next;
      r_err    <= w_err_next;
      r_rdata  <= w_rdata_next;
      r_enable <= w_enable_next;
      r_mode   <= w_mode_next;
      r_addr   <= w_addr_next;
      r_wdata  <= w_wdata_next;
    end
  end

  assign bus.grant             = r_grant;
  assign bus.done              = r_done;
  assign bus.err               = r_err;
  assign bus.rdata             = r_rdata;
  assign bus.busy              = (r_state != ARB_IDLE);
  assign bus.i2c_enable        = r_enable;
  assign bus.i2c_mode          = r_mode;
  assign bus.i2c_periph_addr   = r_addr;
  assign bus.i2c_transmit_byte = r_wdata;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Bench for i2c_bus_arbiter: directed scenarios plus randomized clients and controller,
// checked every cycle against a transaction-level reference model.
module tb_i2c_bus_arbiter;
  import i2c_pkg::*;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 16;
  localparam int HOLDOFF = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  i2c_bus_arbiter_if #(.NREQ(NREQ)) bus ();

  i2c_bus_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .HOLDOFF(HOLDOFF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_txn = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Controller stand-in: ready idles high, drops after c_drop cycles of enable, rises again
  // after c_act low cycles; a hung transfer never drops ready.
  bit         cfg_random = 1'b0;
  bit         cfg_hang   = 1'b0;
  bit         rb_rand    = 1'b1;
  int         cfg_drop   = 2;
  int         cfg_act    = 3;
  logic [7:0] cfg_rb     = 8'h00;

  initial begin
    int c_cnt, c_drop, c_act;
    bit c_hang;
    c_cnt = 0; c_drop = 1; c_act = 1; c_hang = 1'b0;
    bus.i2c_ready     = 1'b1;
    bus.i2c_read_byte = 8'h00;
    forever begin
      @(negedge clk);
      bus.i2c_read_byte = rb_rand ? 8'($urandom) : cfg_rb;
      if (bus.i2c_enable !== 1'b1) begin
        bus.i2c_ready = 1'b1;
        c_cnt = 0;
      end else begin
        if (c_cnt == 0) begin
          if (cfg_random) begin
            c_hang = ($urandom_range(0, 19) == 0);
            c_drop = $urandom_range(1, 3);
            c_act  = $urandom_range(1, 8);
          end else begin
            c_hang = cfg_hang;
            c_drop = cfg_drop;
            c_act  = cfg_act;
          end
        end
        c_cnt++;
        bus.i2c_ready = c_hang || !(c_cnt >= c_drop && c_cnt < c_drop + c_act);
      end
    end
  end

  // Reference model: owner index, age since launch, and remaining settle cycles.
  logic [NREQ-1:0] e_grant, e_done, e_err;
  logic [7:0]      e_rdata, e_wdata;
  logic [6:0]      e_addr;
  logic            e_busy, e_en, e_mode;

  initial begin
    int  m_owner, m_ptr, m_age, m_hold;
    bit  m_low, fin, fin_err;
    m_owner = -1; m_ptr = NREQ - 1; m_age = 0; m_hold = 0; m_low = 1'b0;
    e_grant = '0; e_done = '0; e_err = '0; e_rdata = '0; e_wdata = '0;
    e_addr = '0; e_busy = 1'b0; e_en = 1'b0; e_mode = 1'b0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_owner = -1; m_ptr = NREQ - 1; m_age = 0; m_hold = 0; m_low = 1'b0;
        e_grant = '0; e_done = '0; e_err = '0; e_rdata = '0; e_wdata = '0;
        e_addr = '0; e_busy = 1'b0; e_en = 1'b0; e_mode = 1'b0;
      end else begin
        e_done = '0;
        e_err  = '0;
        fin = 1'b0; fin_err = 1'b0;
        if (m_owner >= 0) begin
          m_age++;
          if (!m_low) begin
            if (m_age == TIMEOUT - 1) begin fin = 1'b1; fin_err = 1'b1; end
            else if (!bus.i2c_ready)  m_low = 1'b1;
          end else if (bus.i2c_ready) begin
            fin = 1'b1;
          end else if (m_age == TIMEOUT - 1) begin
            fin = 1'b1; fin_err = 1'b1;
          end
          if (fin) begin
            if (fin_err) e_err = e_grant;
            else begin
              e_done = e_grant;
              if (e_mode == MODE_READ) e_rdata = bus.i2c_read_byte;
            end
            e_grant = '0; e_en = 1'b0; m_owner = -1; m_hold = HOLDOFF;
          end
        end else if (m_hold > 0) begin
          m_hold--;
        end else if (bus.req != '0) begin
          for (int k = 1; k <= NREQ; k++) begin
            if (m_owner < 0 && bus.req[(m_ptr + k) % NREQ]) m_owner = (m_ptr + k) % NREQ;
          end
          m_ptr   = m_owner;
          m_age   = 0;
          m_low   = 1'b0;
          e_grant = NREQ'(1) << m_owner;
          e_en    = 1'b1;
          e_addr  = bus.req_addr[7*m_owner +: 7];
          e_mode  = bus.req_mode[m_owner];
          e_wdata = bus.req_wdata[8*m_owner +: 8];
        end
        e_busy = (m_owner >= 0) || (m_hold > 0);
      end
    end
  end

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("grant", bus.grant, e_grant);
      chk("done", bus.done, e_done);
      chk("err", bus.err, e_err);
      chk("rdata", bus.rdata, e_rdata);
      chk("busy", bus.busy, e_busy);
      chk("i2c_enable", bus.i2c_enable, e_en);
      if (e_en) begin
        chk("i2c_mode", bus.i2c_mode, e_mode);
        chk("i2c_periph_addr", bus.i2c_periph_addr, e_addr);
        chk("i2c_transmit_byte", bus.i2c_transmit_byte, e_wdata);
      end
      chk("grant_onehot0", $onehot0(bus.grant), 1);
      chk("done_err_excl", |(bus.done & bus.err), 0);
      if (|bus.done || |bus.err) begin
        n_txn++;
        $display("txn %0d: cycle %0d done=%b err=%b rdata=%02h", n_txn, cyc, bus.done, bus.err, bus.rdata);
      end
    end
  end

  task automatic wait_end(input int i, input int maxc, output bit got_err);
    bit seen;
    seen = 1'b0;
    got_err = 1'b0;
    for (int k = 0; k < maxc && !seen; k++) begin
      @(posedge clk);
      #1;
      if (bus.done[i] || bus.err[i]) begin
        seen = 1'b1;
        got_err = bus.err[i];
      end
    end
    chk($sformatf("end_seen_req%0d", i), seen, 1);
  endtask

  task automatic wait_grant(input int maxc, output int idx);
    bit seen;
    seen = 1'b0;
    idx = -1;
    for (int k = 0; k < maxc && !seen; k++) begin
      @(posedge clk);
      #1;
      if (bus.grant != '0) begin
        seen = 1'b1;
        for (int j = 0; j < NREQ; j++) if (bus.grant[j]) idx = j;
      end
    end
    chk("grant_seen", seen, 1);
  endtask

  task automatic wait_idle(input int maxc);
    int k;
    k = 0;
    while (bus.busy && k < maxc) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("idle_seen", bus.busy, 0);
  endtask

  initial begin
    bit ge;
    int w, g_cyc, e_cyc, l_cyc, n;
    bus.req = '0; bus.req_addr = '0; bus.req_mode = '0; bus.req_wdata = '0;
    e_cyc = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", bus.grant, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_enable", bus.i2c_enable, 0);
    chk("rst_rdata", bus.rdata, 0);
    @(negedge clk) reset = 1'b0;

    // Single write
    @(negedge clk);
    bus.req_addr[6:0] = 7'h1A; bus.req_mode[0] = MODE_WRITE; bus.req_wdata[7:0] = 8'h3C;
    bus.req = 2'b01;
    @(posedge clk); #1;
    chk("wr_grant", bus.grant, 2'b01);
    chk("wr_enable", bus.i2c_enable, 1);
    chk("wr_addr", bus.i2c_periph_addr, 7'h1A);
    chk("wr_tx", bus.i2c_transmit_byte, 8'h3C);
    wait_end(0, 40, ge);
    chk("wr_no_err", ge, 0);
    chk("wr_enable_low_at_done", bus.i2c_enable, 0);
    chk("wr_rdata", bus.rdata, 8'h00);
    @(negedge clk) bus.req = '0;
    @(posedge clk); #1;
    chk("wr_done_one_clk", bus.done, 0);

    // Read
    @(negedge clk);
    rb_rand = 1'b0; cfg_rb = 8'hA5;
    bus.req_mode[1] = MODE_READ; bus.req_addr[13:7] = 7'h50; bus.req = 2'b10;
    wait_end(1, 60, ge);
    chk("rd_no_err", ge, 0);
    chk("rd_rdata", bus.rdata, 8'hA5);
    @(negedge clk) bus.req = '0;
    n = 0;
    while (bus.busy && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rd_holdoff_len", n, HOLDOFF);
    rb_rand = 1'b1;

    // Contention, requests held throughout
    wait_idle(40);
    @(negedge clk) bus.req = 2'b11;
    for (int t = 0; t < 4; t++) begin
      wait_grant(40, w);
      g_cyc = cyc;
      chk($sformatf("rr_order%0d", t), w, t % 2);
      if (t > 0) chk($sformatf("rr_gap%0d", t), g_cyc - e_cyc, HOLDOFF + 1);
      wait_end((w < 0) ? 0 : w, 40, ge);
      e_cyc = cyc;
      chk($sformatf("rr_no_err%0d", t), ge, 0);
    end
    @(negedge clk) bus.req = '0;

    // Timeout: ready never drops
    wait_idle(40);
    @(negedge clk) begin cfg_hang = 1'b1; bus.req = 2'b01; end
    @(posedge clk); #1;
    chk("to_grant", bus.grant, 2'b01);
    l_cyc = cyc;
    wait_end(0, 40, ge);
    chk("to_err", ge, 1);
    chk("to_latency", cyc - l_cyc, TIMEOUT - 1);
    chk("to_enable_low", bus.i2c_enable, 0);
    chk("to_no_done", bus.done, 0);
    @(negedge clk) begin bus.req = 2'b10; cfg_hang = 1'b0; end
    wait_end(1, 60, ge);
    chk("to_next_served", ge, 0);
    @(negedge clk) bus.req = '0;

    // Mid-transaction changes
    wait_idle(40);
    @(negedge clk) begin
      cfg_drop = 1; cfg_act = 6;
      bus.req_addr[6:0] = 7'h55; bus.req = 2'b01;
    end
    @(posedge clk); #1;
    chk("mid_grant", bus.grant, 2'b01);
    @(posedge clk); #1;
    @(negedge clk) begin
      bus.req_addr[6:0] = 7'h2B; bus.req_wdata[7:0] = 8'hEE; bus.req[0] = 1'b0;
    end
    @(posedge clk); #1;
    chk("mid_addr_held", bus.i2c_periph_addr, 7'h55);
    wait_end(0, 20, ge);
    chk("mid_done_after_drop", ge, 0);

    // Reset during ACTIVE
    wait_idle(40);
    @(negedge clk) begin cfg_act = 8; bus.req = 2'b10; end
    @(posedge clk); #1;
    chk("ra_grant", bus.grant, 2'b10);
    @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("ra_grant0", bus.grant, 0);
    chk("ra_enable0", bus.i2c_enable, 0);
    chk("ra_busy0", bus.busy, 0);
    chk("ra_done0", bus.done, 0);
    chk("ra_err0", bus.err, 0);
    chk("ra_rdata0", bus.rdata, 0);
    chk("ra_addr0", bus.i2c_periph_addr, 0);
    @(negedge clk) bus.req = 2'b11;
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    chk("ra_first_winner", bus.grant, 2'b01);
    wait_end(0, 40, ge);
    @(negedge clk) bus.req = '0;

    // Randomized clients and controller
    cfg_random = 1'b1;
    repeat (3000) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req[i] && (bus.done[i] || bus.err[i]))
          bus.req[i] = ($urandom_range(0, 3) == 0);
        else if (bus.req[i] && bus.grant[i] && $urandom_range(0, 15) == 0)
          bus.req[i] = 1'b0;
        else if (!bus.req[i] && $urandom_range(0, 3) == 0)
          bus.req[i] = 1'b1;
        if ($urandom_range(0, 2) == 0) begin
          bus.req_addr[7*i +: 7]  = 7'($urandom);
          bus.req_mode[i]         = 1'($urandom);
          bus.req_wdata[8*i +: 8] = 8'($urandom);
        end
      end
    end
    @(negedge clk) begin bus.req = '0; cfg_random = 1'b0; end
    wait_idle(60);
    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
